// File: rtl/i2c_resp_pkg.sv
// Shared definitions for the 16-bit-subaddress I2C responder.
//   ADDR_W / DATA_W : register address and data widths
//   RW_BIT          : position of the R/W flag inside the device address byte
//   i2c_state_e     : protocol state encoding used by i2c_reg16_responder
package i2c_resp_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int RW_BIT = 0;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_DEV      = 4'd1,
        ST_DEV_ACK  = 4'd2,
        ST_AHI      = 4'd3,
        ST_AHI_ACK  = 4'd4,
        ST_ALO      = 4'd5,
        ST_ALO_ACK  = 4'd6,
        ST_WDAT     = 4'd7,
        ST_WDAT_ACK = 4'd8,
        ST_RDAT     = 4'd9,
        ST_RDAT_ACK = 4'd10,
        ST_IGNORE   = 4'd11
    } i2c_state_e;

    // True when the upper seven bits of a received address byte select this target.
    function automatic logic dev_match(input logic [DATA_W-1:0] addr_byte,
                                       input logic [6:0]        dev_addr);
        return addr_byte[DATA_W-1:1] == dev_addr;
    endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Conditions one raw I2C pin: two-flop synchronizer followed by a glitch
// filter that only moves the filtered level after FILTER_LEN consecutive
// samples disagree with it. Rise/fall pulses are registered together with
// the level, so pin edge to event is 2 + FILTER_LEN clocks.
//   clk, rst_n : system clock, async active-low reset
//   pin_in     : raw pin level
//   level      : filtered level (resets high, the idle bus level)
//   rise, fall : one-clock pulses on filtered level changes
module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_in,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q holds how many disagreeing samples have been seen so far; any
    // agreeing sample clears it, so a shorter pulse never reaches the level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        rise_d = level_d & ~level_q;
        fall_d = ~level_d & level_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= pin_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/i2c_reg16_responder.sv
// I2C target for 16-bit subaddress / 8-bit data register access with
// auto-increment. Writes leave as one-clock strobes; reads are sourced from
// an external register file addressed by the current pointer.
//   clk, rst_n     : system clock (>= 20x SCL), async active-low reset
//   scl_in, sda_in : raw bus pin levels
//   sda_oe         : 1 pulls SDA low, 0 releases
//   reg_wr_en      : one-clock write strobe with reg_wr_addr / reg_wr_data
//   reg_rd_addr    : register pointer; reg_rd_data must follow it within 1 clk
//   busy           : high from an addressed START until STOP
//
// state       | meaning
// ------------+-------------------------------------------------------------
// IDLE        | bus free or after STOP
// DEV         | shifting in device address + R/W
// DEV_ACK     | ACKing our address; at its end go to AHI (write) or RDAT
// AHI         | shifting in subaddress high byte
// AHI_ACK     | ACKing high byte
// ALO         | shifting in subaddress low byte; pointer loads at 8th bit
// ALO_ACK     | ACKing low byte
// WDAT        | shifting in a write data byte; strobe at 8th bit
// WDAT_ACK    | ACKing write data
// RDAT        | driving a read byte MSB first
// RDAT_ACK    | SDA released, sampling master ACK/NACK
// IGNORE      | not addressed or read NACKed; wait for START/STOP
//
// ACK states span two SCL falls: the first fall starts driving (or releases
// for a master ACK), the second fall ends the slot. ack_fall_q marks that the
// first fall has already happened.
module i2c_reg16_responder
    import i2c_resp_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = 7'h30,
    parameter int         FILTER_LEN = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic              reg_wr_en,
    output logic [ADDR_W-1:0] reg_wr_addr,
    output logic [DATA_W-1:0] reg_wr_data,
    output logic [ADDR_W-1:0] reg_rd_addr,
    input  logic [DATA_W-1:0] reg_rd_data,
    output logic              busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin_in (scl_in),
        .level  (scl_lvl),
        .rise   (scl_rise),
        .fall   (scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin_in (sda_in),
        .level  (sda_lvl),
        .rise   (sda_rise),
        .fall   (sda_fall)
    );

    // SDA moving while the filtered SCL is still high marks START/STOP.
    logic start_evt, stop_evt;
    assign start_evt = sda_fall & scl_lvl;
    assign stop_evt  = sda_rise & scl_lvl;

    i2c_state_e        state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              ack_fall_q, ack_fall_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] addr_hi_q, addr_hi_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              sda_oe_q, sda_oe_d;
    logic              busy_q, busy_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [DATA_W-1:0] rx_byte;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ack_fall_d = ack_fall_q;
        rw_d       = rw_q;
        addr_hi_d  = addr_hi_q;
        ptr_d      = ptr_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rx_byte    = {shift_q[DATA_W-2:0], sda_lvl};

        if (start_evt) begin
            // Repeated START keeps the pointer and busy; only framing restarts.
            state_d    = ST_DEV;
            bit_cnt_d  = 3'd7;
            ack_fall_d = 1'b0;
        end else if (stop_evt) begin
            state_d    = ST_IDLE;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
            ack_fall_d = 1'b0;
        end else if (scl_rise) begin
            case (state_q)
                ST_DEV, ST_AHI, ST_ALO, ST_WDAT: begin
                    shift_d = rx_byte;
                    if (bit_cnt_q != 3'd0) begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end else begin
                        ack_fall_d = 1'b0;
                        case (state_q)
                            ST_DEV: begin
                                if (dev_match(rx_byte, DEV_ADDR)) begin
                                    state_d = ST_DEV_ACK;
                                    rw_d    = rx_byte[RW_BIT];
                                    busy_d  = 1'b1;
                                end else begin
                                    state_d = ST_IGNORE;
                                end
                            end
                            ST_AHI: begin
                                addr_hi_d = rx_byte;
                                state_d   = ST_AHI_ACK;
                            end
                            ST_ALO: begin
                                ptr_d   = {addr_hi_q, rx_byte};
                                state_d = ST_ALO_ACK;
                            end
                            default: begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = ptr_q;
                                wr_data_d = rx_byte;
                                ptr_d     = ptr_q + ADDR_W'(1);
                                state_d   = ST_WDAT_ACK;
                            end
                        endcase
                    end
                end
                ST_RDAT: begin
                    if (bit_cnt_q != 3'd0) begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end else begin
                        state_d    = ST_RDAT_ACK;
                        ack_fall_d = 1'b0;
                    end
                end
                ST_RDAT_ACK: begin
                    // The pointer advances after every byte read, ACKed or not.
                    if (ack_fall_q) begin
                        ptr_d = ptr_q + ADDR_W'(1);
                        if (sda_lvl) begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end else if (scl_fall) begin
            case (state_q)
                ST_DEV_ACK, ST_AHI_ACK, ST_ALO_ACK, ST_WDAT_ACK: begin
                    if (!ack_fall_q) begin
                        sda_oe_d   = 1'b1;
                        ack_fall_d = 1'b1;
                    end else begin
                        sda_oe_d   = 1'b0;
                        ack_fall_d = 1'b0;
                        bit_cnt_d  = 3'd7;
                        case (state_q)
                            ST_DEV_ACK: begin
                                if (rw_q) begin
                                    state_d  = ST_RDAT;
                                    shift_d  = reg_rd_data;
                                    sda_oe_d = ~reg_rd_data[DATA_W-1];
                                end else begin
                                    state_d = ST_AHI;
                                end
                            end
                            ST_AHI_ACK: state_d = ST_ALO;
                            default:    state_d = ST_WDAT;
                        endcase
                    end
                end
                ST_RDAT: begin
                    sda_oe_d = ~shift_q[bit_cnt_q];
                end
                ST_RDAT_ACK: begin
                    if (!ack_fall_q) begin
                        sda_oe_d   = 1'b0;
                        ack_fall_d = 1'b1;
                    end else begin
                        state_d    = ST_RDAT;
                        ack_fall_d = 1'b0;
                        bit_cnt_d  = 3'd7;
                        shift_d    = reg_rd_data;
                        sda_oe_d   = ~reg_rd_data[DATA_W-1];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd7;
            shift_q    <= '0;
            ack_fall_q <= 1'b0;
            rw_q       <= 1'b0;
            addr_hi_q  <= '0;
            ptr_q      <= '0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ack_fall_q <= ack_fall_d;
            rw_q       <= rw_d;
            addr_hi_q  <= addr_hi_d;
            ptr_q      <= ptr_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign sda_oe      = sda_oe_q;
    assign reg_wr_en   = wr_en_q;
    assign reg_wr_addr = wr_addr_q;
    assign reg_wr_data = wr_data_q;
    assign reg_rd_addr = ptr_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_i2c_reg16_responder.sv
// Directed bench for i2c_reg16_responder: a bit-banged I2C master with an
// SCL period of 40 system clocks, an open-drain SDA wire and a small
// register-file model feeding reg_rd_data one clock after reg_rd_addr.
module tb_i2c_reg16_responder;
    import i2c_resp_pkg::*;

    localparam int Q = 10;  // quarter SCL period in system clocks

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_oe, reg_wr_en, busy;
    logic [15:0] reg_wr_addr, reg_rd_addr;
    logic [7:0]  reg_wr_data;
    logic [7:0]  reg_rd_data = 8'h00;

    wire sda_bus = sda_m & ~sda_oe;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] wr_addr_log[$];
    logic [7:0]  wr_data_log[$];
    logic        oe_seen   = 1'b0;
    logic        busy_seen = 1'b0;

    always #5 clk = ~clk;

    i2c_reg16_responder #(.DEV_ADDR(7'h30), .FILTER_LEN(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scl_in      (scl_m),
        .sda_in      (sda_bus),
        .sda_oe      (sda_oe),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .reg_rd_addr (reg_rd_addr),
        .reg_rd_data (reg_rd_data),
        .busy        (busy)
    );

    function automatic logic [7:0] rd_model(input logic [15:0] a);
        case (a)
            16'h3107: return 8'h22;
            16'h3108: return 8'h10;
            default:  return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    always @(posedge clk) reg_rd_data <= rd_model(reg_rd_addr);

    always @(negedge clk) begin
        if (reg_wr_en) begin
            wr_addr_log.push_back(reg_wr_addr);
            wr_data_log.push_back(reg_wr_data);
        end
        if (sda_oe) oe_seen = 1'b1;
        if (busy)   busy_seen = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(2 * Q);
    endtask

    task automatic clock_bit(input logic b, output logic smp);
        sda_m = b;    tick(Q);
        scl_m = 1'b1; tick(Q);
        smp = sda_bus; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            b[i] = s;
        end
        clock_bit(nack, s);
    endtask

    initial begin
        logic       a0, a1, a2, a3, a4, a5, s;
        logic [7:0] rb;
        int         k;

        // ---------------- reset values
        tick(3);
        check("rst_sda_oe",  32'(sda_oe), 32'h0);
        check("rst_wr_en",   32'(reg_wr_en), 32'h0);
        check("rst_wr_addr", 32'(reg_wr_addr), 32'h0);
        check("rst_wr_data", 32'(reg_wr_data), 32'h0);
        check("rst_rd_addr", 32'(reg_rd_addr), 32'h0);
        check("rst_busy",    32'(busy), 32'h0);
        rst_n = 1'b1;
        tick(Q);

        // ---------------- single write 0x3E01 <= 0x45
        i2c_start();
        write_byte(8'h60, a0);
        write_byte(8'h3E, a1);
        write_byte(8'h01, a2);
        write_byte(8'h45, a3);
        check("w1_acks", 32'({a0, a1, a2, a3}), 32'hF);
        check("w1_busy_high", 32'(busy), 32'h1);
        i2c_stop();
        tick(4);
        check("w1_strobe_count", 32'(wr_addr_log.size()), 32'd1);
        check("w1_wr_addr", 32'(wr_addr_log[0]), 32'h3E01);
        check("w1_wr_data", 32'(wr_data_log[0]), 32'h45);
        check("w1_busy_low", 32'(busy), 32'h0);
        check("w1_pointer", 32'(reg_rd_addr), 32'h3E02);

        // ---------------- burst write with pointer wrap at FFFF
        i2c_start();
        write_byte(8'h60, a0);
        write_byte(8'hFF, a1);
        write_byte(8'hFF, a2);
        write_byte(8'hA1, a3);
        write_byte(8'hA2, a4);
        write_byte(8'hA3, a5);
        check("w2_acks", 32'({a0, a1, a2, a3, a4, a5}), 32'h3F);
        i2c_stop();
        tick(4);
        check("w2_strobe_count", 32'(wr_addr_log.size()), 32'd4);
        check("w2_addr0", 32'(wr_addr_log[1]), 32'hFFFF);
        check("w2_data0", 32'(wr_data_log[1]), 32'hA1);
        check("w2_addr1", 32'(wr_addr_log[2]), 32'h0000);
        check("w2_data1", 32'(wr_data_log[2]), 32'hA2);
        check("w2_addr2", 32'(wr_addr_log[3]), 32'h0001);
        check("w2_data2", 32'(wr_data_log[3]), 32'hA3);
        check("w2_pointer", 32'(reg_rd_addr), 32'h0002);

        // ---------------- random read via repeated START
        i2c_start();
        write_byte(8'h60, a0);
        write_byte(8'h31, a1);
        write_byte(8'h07, a2);
        check("r_addr_acks", 32'({a0, a1, a2}), 32'h7);
        check("r_ptr_set", 32'(reg_rd_addr), 32'h3107);
        i2c_start();
        write_byte(8'h61, a3);
        check("r_dev_ack", 32'(a3), 32'h1);
        read_byte(1'b0, rb);
        check("r_byte0", 32'(rb), 32'h22);
        check("r_ptr_after0", 32'(reg_rd_addr), 32'h3108);
        read_byte(1'b1, rb);
        check("r_byte1", 32'(rb), 32'h10);
        check("r_ptr_after1", 32'(reg_rd_addr), 32'h3109);
        check("r_busy_before_stop", 32'(busy), 32'h1);
        i2c_stop();
        tick(4);
        check("r_no_strobe", 32'(wr_addr_log.size()), 32'd4);
        check("r_busy_low", 32'(busy), 32'h0);

        // ---------------- foreign address 0x62 is ignored
        oe_seen   = 1'b0;
        busy_seen = 1'b0;
        i2c_start();
        write_byte(8'h62, a0);
        write_byte(8'h55, a1);
        check("x_no_ack_dev", 32'(a0), 32'h0);
        check("x_no_ack_data", 32'(a1), 32'h0);
        i2c_stop();
        tick(4);
        check("x_sda_never_pulled", 32'(oe_seen), 32'h0);
        check("x_busy_never", 32'(busy_seen), 32'h0);
        check("x_no_strobe", 32'(wr_addr_log.size()), 32'd4);

        i2c_start();
        write_byte(8'h60, a0);
        write_byte(8'h12, a1);
        write_byte(8'h34, a2);
        write_byte(8'h56, a3);
        i2c_stop();
        tick(4);
        check("x_next_acks", 32'({a0, a1, a2, a3}), 32'hF);
        check("x_next_count", 32'(wr_addr_log.size()), 32'd5);
        check("x_next_addr", 32'(wr_addr_log[4]), 32'h1234);
        check("x_next_data", 32'(wr_data_log[4]), 32'h56);

        // ---------------- STOP after 5 bits of a data byte
        i2c_start();
        write_byte(8'h60, a0);
        write_byte(8'h00, a1);
        write_byte(8'h10, a2);
        rb = 8'hC3;
        for (int i = 7; i >= 3; i--) clock_bit(rb[i], s);
        i2c_stop();
        tick(4);
        check("p_no_strobe", 32'(wr_addr_log.size()), 32'd5);
        check("p_sda_oe", 32'(sda_oe), 32'h0);
        check("p_busy", 32'(busy), 32'h0);
        check("p_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
        check("p_pointer", 32'(reg_rd_addr), 32'h0010);

        // ---------------- reset while ACKing the device address
        i2c_start();
        rb = 8'h60;
        for (int i = 7; i >= 0; i--) clock_bit(rb[i], s);
        sda_m = 1'b1;
        k = 0;
        while (!sda_oe && k < 4 * Q) begin
            tick(1);
            k++;
        end
        check("rs_ack_driving", 32'(sda_oe), 32'h1);
        rst_n = 1'b0;
        #1;
        check("rs_sda_released", 32'(sda_oe), 32'h0);
        tick(2);
        check("rs_busy", 32'(busy), 32'h0);
        check("rs_pointer", 32'(reg_rd_addr), 32'h0000);
        scl_m = 1'b1;
        tick(Q);
        rst_n = 1'b1;
        tick(2 * Q);
        check("rs_state_idle", 32'(dut.state_q), 32'(ST_IDLE));

        // ---------------- SDA glitches while SCL high
        sda_m = 1'b0; tick(1); sda_m = 1'b1;
        tick(2 * Q);
        check("g_1clk_no_start", 32'(dut.state_q), 32'(ST_IDLE));
        sda_m = 1'b0; tick(2); sda_m = 1'b1;
        tick(2 * Q);
        check("g_2clk_no_start", 32'(dut.state_q), 32'(ST_IDLE));
        sda_m = 1'b0; tick(Q);
        check("g_long_is_start", 32'(dut.state_q), 32'(ST_DEV));
        sda_m = 1'b1; tick(Q);
        check("g_long_is_stop", 32'(dut.state_q), 32'(ST_IDLE));
        check("g_busy", 32'(busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
